// File: rtl/scale_pipe.sv
// Two-stage raster-to-source coordinate mapper: per-axis power-of-two scale,
// pan offsets, bounds check and linear frame-buffer address generation.
module scale_pipe #(
  parameter int H_W     = 11,
  parameter int V_W     = 10,
  parameter int SRC_H   = 320,
  parameter int SRC_V   = 240,
  parameter int ADDR_W  = 17,
  parameter int SHIFT_W = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_W-1:0]     hcount_in,
  input  logic [V_W-1:0]     vcount_in,
  input  logic [SHIFT_W-1:0] hshift_in,
  input  logic [SHIFT_W-1:0] vshift_in,
  input  logic [H_W-1:0]     hoff_in,
  input  logic [V_W-1:0]     voff_in,
  output logic [H_W-1:0]     scaled_hcount_out,
  output logic [V_W-1:0]     scaled_vcount_out,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               valid_addr_out,
  output logic               frame_start_out
);

  // Free-running stream: one pixel accepted and one produced every cycle,
  // no valid/ready handshake and no backpressure; latency is fixed at 2.

  logic               frame_start;
  logic [SHIFT_W-1:0] hshift_q, vshift_q;
  logic [H_W-1:0]     hoff_q;
  logic [V_W-1:0]     voff_q;

  logic [SHIFT_W-1:0] eff_hshift, eff_vshift;
  logic [H_W-1:0]     eff_hoff;
  logic [V_W-1:0]     eff_voff;
  logic [H_W-1:0]     dh;
  logic [V_W-1:0]     dv;

  logic               s1_live;
  logic               s1_uh, s1_uv;
  logic [H_W-1:0]     s1_sx;
  logic [V_W-1:0]     s1_sy;
  logic               s1_fs;

  logic               s2_valid;
  logic [ADDR_W-1:0]  s2_addr;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);

  // The frame-start pixel already uses the settings being loaded on this edge.
  assign eff_hshift = frame_start ? hshift_in : hshift_q;
  assign eff_vshift = frame_start ? vshift_in : vshift_q;
  assign eff_hoff   = frame_start ? hoff_in   : hoff_q;
  assign eff_voff   = frame_start ? voff_in   : voff_q;

  assign dh = hcount_in - eff_hoff;
  assign dv = vcount_in - eff_voff;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hshift_q <= '0;
      vshift_q <= '0;
      hoff_q   <= '0;
      voff_q   <= '0;
    end else if (frame_start) begin
      hshift_q <= hshift_in;
      vshift_q <= vshift_in;
      hoff_q   <= hoff_in;
      voff_q   <= voff_in;
    end
  end

  // s1_live keeps the cleared stage-1 contents from looking like pixel (0,0).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_live <= 1'b0;
      s1_uh   <= 1'b0;
      s1_uv   <= 1'b0;
      s1_sx   <= '0;
      s1_sy   <= '0;
      s1_fs   <= 1'b0;
    end else begin
      s1_live <= 1'b1;
      s1_uh   <= (hcount_in < eff_hoff);
      s1_uv   <= (vcount_in < eff_voff);
      s1_sx   <= dh >> eff_hshift;
      s1_sy   <= dv >> eff_vshift;
      s1_fs   <= frame_start;
    end
  end

  assign s2_valid = s1_live && !s1_uh && !s1_uv &&
                    ({1'b0, s1_sx} < (H_W+1)'(SRC_H)) &&
                    ({1'b0, s1_sy} < (V_W+1)'(SRC_V));
  assign s2_addr  = ADDR_W'(s1_sy) * ADDR_W'(SRC_H) + ADDR_W'(s1_sx);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scaled_hcount_out <= '0;
      scaled_vcount_out <= '0;
      addr_out          <= '0;
      valid_addr_out    <= 1'b0;
      frame_start_out   <= 1'b0;
    end else begin
      scaled_hcount_out <= s2_valid ? s1_sx   : '0;
      scaled_vcount_out <= s2_valid ? s1_sy   : '0;
      addr_out          <= s2_valid ? s2_addr : '0;
      valid_addr_out    <= s2_valid;
      frame_start_out   <= s1_fs;
    end
  end

endmodule

// File: tb/tb_scale_pipe.sv
// Bench for scale_pipe: directed vector table, hand-written reset/frame-pulse
// sequences and randomized traffic against an arithmetic reference model.
module tb_scale_pipe;
  localparam int H_W = 11, V_W = 10, SRC_H = 320, SRC_V = 240;
  localparam int ADDR_W = 17, SHIFT_W = 2;
  localparam int EW = 2 + ADDR_W + V_W + H_W;

  logic               clk = 1'b0;
  logic               rst;
  logic [H_W-1:0]     hcount, hoff;
  logic [V_W-1:0]     vcount, voff;
  logic [SHIFT_W-1:0] hshift, vshift;
  logic [H_W-1:0]     sx_out;
  logic [V_W-1:0]     sy_out;
  logic [ADDR_W-1:0]  addr_out;
  logic               valid_out, fs_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  int m_hs = 0, m_vs = 0, m_ho = 0, m_vo = 0;

  typedef struct {
    int hs, vs, ho, vo, h, v;
    int ex, ey, ea, ev;
  } vec_t;
  vec_t vecs[12];

  scale_pipe #(.H_W(H_W), .V_W(V_W), .SRC_H(SRC_H), .SRC_V(SRC_V),
               .ADDR_W(ADDR_W), .SHIFT_W(SHIFT_W)) dut (
    .clk_in(clk), .rst_in(rst),
    .hcount_in(hcount), .vcount_in(vcount),
    .hshift_in(hshift), .vshift_in(vshift),
    .hoff_in(hoff), .voff_in(voff),
    .scaled_hcount_out(sx_out), .scaled_vcount_out(sy_out),
    .addr_out(addr_out), .valid_addr_out(valid_out),
    .frame_start_out(fs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int hs, int vs, int ho, int vo, int h, int v,
                              int ex, int ey, int ea, int ev);
    vec_t r;
    r.hs = hs; r.vs = vs; r.ho = ho; r.vo = vo; r.h = h; r.v = v;
    r.ex = ex; r.ey = ey; r.ea = ea; r.ev = ev;
    return r;
  endfunction

  task automatic set_ports(input int h, input int v, input int hs, input int vs,
                           input int ho, input int vo);
    hcount = H_W'(h);
    vcount = V_W'(v);
    hshift = SHIFT_W'(hs);
    vshift = SHIFT_W'(vs);
    hoff   = H_W'(ho);
    voff   = V_W'(vo);
  endtask

  task automatic frame_start(input int hs, input int vs, input int ho, input int vo);
    @(negedge clk);
    set_ports(0, 0, hs, vs, ho, vo);
    @(posedge clk);
  endtask

  // Pixel with junk settings on the ports (must be ignored mid-frame).
  task automatic apply_pixel(input int h, input int v);
    @(negedge clk);
    set_ports(h, v, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 50), $urandom_range(0, 50));
    @(posedge clk);
    @(negedge clk);
    set_ports(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
  endtask

  // Reference: shadow update at frame start, then plain integer arithmetic.
  task automatic drive(input int h, input int v, input int hs, input int vs,
                       input int ho, input int vo);
    int sx, sy, ok, fs;
    logic [EW-1:0] e, act;
    @(negedge clk);
    set_ports(h, v, hs, vs, ho, vo);
    fs = (h == 0 && v == 0);
    if (fs != 0) begin
      m_hs = hs; m_vs = vs; m_ho = ho; m_vo = vo;
    end
    ok = 0; sx = 0; sy = 0;
    if (h >= m_ho && v >= m_vo) begin
      sx = (h - m_ho) / (1 << m_hs);
      sy = (v - m_vo) / (1 << m_vs);
      ok = (sx < SRC_H && sy < SRC_V);
    end
    if (ok == 0) begin
      sx = 0; sy = 0;
    end
    e = {1'(fs), 1'(ok), ADDR_W'(sy * SRC_H + sx), V_W'(sy), H_W'(sx)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      act = {fs_out, valid_out, addr_out, sy_out, sx_out};
      check("rand_pixel", 64'(act), 64'(e));
    end
  endtask

  initial begin
    int h, v;
    rst = 1'b1;
    set_ports(0, 0, 0, 0, 0, 0);

    vecs[0]  = mk(0, 0, 0, 0, 319, 0,    319, 0,   319,   1);
    vecs[1]  = mk(0, 0, 0, 0, 320, 0,    0,   0,   0,     0);
    vecs[2]  = mk(1, 1, 0, 0, 101, 51,   50,  25,  8050,  1);
    vecs[3]  = mk(1, 1, 0, 0, 640, 10,   0,   0,   0,     0);
    vecs[4]  = mk(0, 0, 8, 4, 7,   4,    0,   0,   0,     0);
    vecs[5]  = mk(0, 0, 8, 4, 8,   4,    0,   0,   0,     1);
    vecs[6]  = mk(0, 0, 0, 0, 200, 100,  200, 100, 32200, 1);
    vecs[7]  = mk(2, 0, 0, 0, 200, 100,  50,  100, 32050, 1);
    vecs[8]  = mk(3, 3, 0, 0, 1000, 1000, 125, 125, 40125, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,   239,  0,   239, 76480, 1);
    vecs[10] = mk(0, 0, 0, 0, 319, 240,  0,   0,   0,     0);
    vecs[11] = mk(2, 0, 0, 10, 5,  3,    0,   0,   0,     0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_x",     64'(sx_out),    64'd0);
    check("reset_y",     64'(sy_out),    64'd0);
    check("reset_addr",  64'(addr_out),  64'd0);
    check("reset_valid", 64'(valid_out), 64'd0);
    check("reset_fs",    64'(fs_out),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      frame_start(vecs[i].hs, vecs[i].vs, vecs[i].ho, vecs[i].vo);
      apply_pixel(vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d_x", i),     64'(sx_out),    64'(vecs[i].ex));
      check($sformatf("vec%0d_y", i),     64'(sy_out),    64'(vecs[i].ey));
      check($sformatf("vec%0d_addr", i),  64'(addr_out),  64'(vecs[i].ea));
      check($sformatf("vec%0d_valid", i), 64'(valid_out), 64'(vecs[i].ev));
      check($sformatf("vec%0d_fs", i),    64'(fs_out),    64'd0);
    end

    // frame_start_out: one-cycle pulse two edges after the (0,0) sample
    frame_start(3, 3, 0, 0);
    #1;
    check("fs_lat1", 64'(fs_out), 64'd0);
    @(negedge clk);
    set_ports(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("fs_lat2", 64'(fs_out), 64'd1);
    check("fs_lat2_valid", 64'(valid_out), 64'd1);
    @(negedge clk);
    set_ports(2, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("fs_lat3", 64'(fs_out), 64'd0);

    // asynchronous reset mid-line
    frame_start(0, 0, 0, 0);
    @(negedge clk);
    set_ports(150, 10, 0, 0, 0, 0);
    @(negedge clk);
    set_ports(151, 10, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_rst_x", 64'(sx_out), 64'd150);
    check("pre_rst_valid", 64'(valid_out), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_x",     64'(sx_out),    64'd0);
    check("async_rst_y",     64'(sy_out),    64'd0);
    check("async_rst_addr",  64'(addr_out),  64'd0);
    check("async_rst_valid", 64'(valid_out), 64'd0);
    check("async_rst_fs",    64'(fs_out),    64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_ports(5, 7, 3, 3, 9, 9);
    @(posedge clk);
    #1;
    check("post_rst_lat1_valid", 64'(valid_out), 64'd0);
    @(negedge clk);
    set_ports(6, 7, 3, 3, 9, 9);
    @(posedge clk);
    #1;
    check("post_rst_x",     64'(sx_out),    64'd5);
    check("post_rst_y",     64'(sy_out),    64'd7);
    check("post_rst_addr",  64'(addr_out),  64'd2245);
    check("post_rst_valid", 64'(valid_out), 64'd1);

    // randomized frames against the reference model
    for (int f = 0; f < 10; f++) begin
      drive(0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 40), $urandom_range(0, 40));
      for (int p = 0; p < 60; p++) begin
        if ($urandom_range(0, 9) == 0) begin
          h = $urandom_range(0, 2047);
          v = $urandom_range(0, 1023);
        end else begin
          h = $urandom_range(0, 700);
          v = $urandom_range(0, 520);
        end
        if (h == 0 && v == 0) h = 1;
        drive(h, v, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 60), $urandom_range(0, 60));
      end
    end
    drive(3, 3, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scale_pipe.md
Name: scale_pipe

Overview:
Pipelined, parametrised successor to the combinational pixel scaler. It maps display raster counts (hcount/vcount) to source-frame coordinates and a linear buffer address. The block adds independent per-axis power-of-two scale, per-axis pan offsets and a source-frame bounds check. Scale and offset settings are shadowed so they change only at frame start. It sits between the video timing generator and the frame-buffer read port.

Parameters:
H_W, 11, hcount width
V_W, 10, vcount width
SRC_H, 320, source frame width in pixels
SRC_V, 240, source frame height in pixels
ADDR_W, 17, address width; must satisfy 2^ADDR_W >= SRC_H*SRC_V
SHIFT_W, 2, width of per-axis shift (scale = 2^shift, max 2^(2^SHIFT_W-1))

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
hcount_in  input  H_W  raster horizontal count
vcount_in  input  V_W  raster vertical count
hshift_in  input  SHIFT_W  requested horizontal scale shift
vshift_in  input  SHIFT_W  requested vertical scale shift
hoff_in  input  H_W  requested horizontal pan offset (display pixels)
voff_in  input  V_W  requested vertical pan offset (display lines)
scaled_hcount_out  output  H_W  source x coordinate
scaled_vcount_out  output  V_W  source y coordinate
addr_out  output  ADDR_W  source y*SRC_H + source x
valid_addr_out  output  1  source coordinate lies inside SRC_H x SRC_V
frame_start_out  output  1  pulse aligned with output of pixel (0,0)

Behaviour:
- One clock, clk_in. Reset is asynchronous and active-high on rst_in. While rst_in is high, all outputs, pipeline registers and shadow registers are 0.
- Shadow registers: hshift, vshift, hoff and voff are loaded from the *_in ports only on a clock edge where hcount_in==0 and vcount_in==0 (frame start). At all other times the ports are ignored.
- The frame-start pixel itself is processed with the newly loaded values: stage 1 selects the port values when frame start is true, otherwise the shadow values.
- Stage 1 (registered):
  - dh = hcount_in - hoff, dv = vcount_in - voff.
  - Underflow flags uh = (hcount_in < hoff), uv = (vcount_in < voff).
  - sx = dh >> hshift, sy = dv >> vshift (logical shift).
  - Frame-start flag is registered alongside.
- Stage 2 (registered):
  - valid = !uh && !uv && sx < SRC_H && sy < SRC_V.
  - If valid: scaled_hcount_out = sx, scaled_vcount_out = sy, addr_out = sy*SRC_H + sx (truncated to ADDR_W).
  - If invalid: all three outputs are 0.
  - frame_start_out follows the stage-1 flag.
- Latency: exactly 2 clk_in cycles from input sample to output, fixed and independent of settings. Throughput is one pixel per cycle.
- Inputs are treated as arbitrary values; no wrap protection is applied beyond the underflow flags.
- Reset mid-frame: the pipeline clears immediately and outputs go to 0. The shadow registers return to shift 0 and offset 0 until the next frame start.
- Settings that change and then revert between two frame starts have no effect.

Test Plan:
- Reset, shift 0/0, offsets 0; input (h=319, v=0) -> 2 cycles later valid=1, x=319, y=0, addr=319. Input (h=320, v=0) -> valid=0, x=y=addr=0.
- Apply shift 1/1 at frame start; input (h=101, v=51) -> x=50, y=25, addr=8050, valid=1. Input (h=640, v=10) -> valid=0.
- hoff=8, voff=4 loaded at frame start, shift 0; input (h=7, v=4) -> valid=0. Input (h=8, v=4) -> x=0, y=0, addr=0, valid=1.
- Active shift 0; change hshift_in to 2 while v=100; input (h=200, v=100) -> x=200. After the next (0,0), input (h=200, v=100) -> x=50, addr=100*320+50 invalid check: y=100, addr=32050, valid=1.
- Shift 3/3; input (h=1000, v=1000) -> x=125, y=125, addr=40125, valid=1. frame_start_out is high exactly 2 cycles after the (0,0) input, for one cycle.
- Assert rst_in asynchronously mid-line at h=150 -> all outputs 0 without waiting for a clock edge. After release, shadow values are shift 0 and offset 0, and the first valid output appears 2 cycles after the first in-range input.
